cap_sort_scheduler: RTL and testbench

CAP_SORT_SCHEDULER -- requirements
Module: cap_sort_scheduler

---
 rtl/cap_sort_scheduler.sv | 94 +++++++++
 tb/tb_cap_sort_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cap_sort_scheduler.sv
// Ranks N capacitor voltages (IEEE-754 single) by magnitude using a fixed-length bubble sort
// that permutes an index array, one compare per cycle.
module cap_sort_scheduler #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             start,
  input  logic [IDX_W-1:0] rank_addr,
  output logic [IDX_W-1:0] rank_idx,
  output logic             busy,
  output logic             done,
  output logic [5:0]       swap_cnt
);

  typedef enum logic [1:0] {StIdle, StInit, StCompare, StDone} state_e;

  localparam logic [IDX_W-1:0] LastPass = IDX_W'(N - 2);

  state_e           state_q;
  logic [31:0]      volt_q [N];
  logic [IDX_W-1:0] idx_q  [N];
  logic [IDX_W-1:0] pass_q;
  logic [IDX_W-1:0] j_q;
  logic [IDX_W-1:0] j_nxt;
  logic [IDX_W-1:0] j_last;
  logic [5:0]       swap_cnt_q;
  logic [30:0]      mag_lo;
  logic [30:0]      mag_hi;
  logic             swap;

  // Exponent sits above mantissa, so an unsigned compare of bits [30:0] orders by magnitude.
  always_comb begin
    j_nxt  = j_q + 1'b1;
    j_last = LastPass - pass_q;
    mag_lo = volt_q[idx_q[j_q]][30:0];
    mag_hi = volt_q[idx_q[j_nxt]][30:0];
    swap   = mag_hi < mag_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pass_q     <= '0;
      j_q        <= '0;
      swap_cnt_q <= '0;
      for (int k = 0; k < N; k++) begin
        volt_q[k] <= '0;
        idx_q[k]  <= IDX_W'(k);
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_en) volt_q[wr_addr] <= wr_data;
          if (start) state_q <= StInit;
        end
        StInit: begin
          for (int k = 0; k < N; k++) idx_q[k] <= IDX_W'(k);
          swap_cnt_q <= '0;
          pass_q     <= '0;
          j_q        <= '0;
          state_q    <= StCompare;
        end
        StCompare: begin
          if (swap) begin
            idx_q[j_q]   <= idx_q[j_nxt];
            idx_q[j_nxt] <= idx_q[j_q];
            swap_cnt_q   <= swap_cnt_q + 6'd1;
          end
          // No early exit: every pass runs to completion so latency is data-independent.
          if (j_q == j_last) begin
            j_q <= '0;
            if (pass_q == LastPass) state_q <= StDone;
            else                    pass_q  <= pass_q + 1'b1;
          end else begin
            j_q <= j_nxt;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rank_idx = idx_q[rank_addr];
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_cap_sort_scheduler.sv
// Directed self-checking bench for cap_sort_scheduler (N=8).
module tb_cap_sort_scheduler;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [2:0]  rank_addr;
  logic [2:0]  rank_idx;
  logic        busy;
  logic        done;
  logic [5:0]  swap_cnt;

  int checks = 0;
  int passes = 0;
  int done_edge, busy_cycles, done_pulses;
  logic [31:0] vals [8];

  localparam logic [23:0] Identity = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [23:0] Reversed = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  cap_sort_scheduler #(
    .N    (8),
    .IDX_W(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .rank_addr(rank_addr),
    .rank_idx (rank_idx),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_ranks(input string tag, input logic [23:0] exp);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      rank_addr = 3'(r);
      #1;
      check($sformatf("%s rank%0d", tag, r), {29'b0, rank_idx}, {29'b0, exp[23-3*r -: 3]});
    end
  endtask

  task automatic write_cap(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic write_vals();
    for (int i = 0; i < 8; i++) write_cap(3'(i), vals[i]);
  endtask

  // Negedge index k lies between edge Ek and E(k+1), with E0 the edge that samples start.
  task automatic run_sort(output int d_edge, output int b_cycles, output int d_pulses);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d_edge = -1; b_cycles = 0; d_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) b_cycles++;
      if (done) begin
        d_pulses++;
        if (d_edge < 0) d_edge = k;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rank_addr = '0;
    #12;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset swap_cnt", {26'b0, swap_cnt}, 32'd0);
    check_ranks("reset", Identity);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed data: 8,1,7,2,6,3,5,4
    vals = '{32'h41000000, 32'h3F800000, 32'h40E00000, 32'h40000000,
             32'h40C00000, 32'h40400000, 32'h40A00000, 32'h40800000};
    write_vals();
    run_sort(done_edge, busy_cycles, done_pulses);
    check("mixed done edge", 32'(done_edge), 32'd29);
    check("mixed done pulses", 32'(done_pulses), 32'd1);
    check("mixed busy cycles", 32'(busy_cycles), 32'd30);
    check_ranks("mixed", {3'd1, 3'd3, 3'd5, 3'd7, 3'd6, 3'd4, 3'd2, 3'd0});

    // All equal: stable, no swaps
    for (int i = 0; i < 8; i++) vals[i] = 32'h3F800000;
    write_vals();
    run_sort(done_edge, busy_cycles, done_pulses);
    check("equal swap_cnt", {26'b0, swap_cnt}, 32'd0);
    check_ranks("equal", Identity);

    // Strictly descending 8..1: worst case
    vals = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
             32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    write_vals();
    run_sort(done_edge, busy_cycles, done_pulses);
    check("desc swap_cnt", {26'b0, swap_cnt}, 32'd28);
    check("desc busy cycles", 32'(busy_cycles), 32'd30);
    check("desc done edge", 32'(done_edge), 32'd29);
    check_ranks("desc", Reversed);

    // Write and second start during a sort are ignored
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_edge = -1; done_pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        done_pulses++;
        if (done_edge < 0) done_edge = k;
      end
      if (k == 5) begin
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h42C80000; start = 1'b1;
      end else if (k == 6) begin
        wr_en = 1'b0; start = 1'b0;
      end
    end
    check("busy-ignore done pulses", 32'(done_pulses), 32'd1);
    check("busy-ignore done edge", 32'(done_edge), 32'd29);
    run_sort(done_edge, busy_cycles, done_pulses);
    check_ranks("busy-ignore", Reversed);

    // Mantissa tie-break and sign-bit magnitude ordering
    for (int i = 0; i < 8; i++) vals[i] = 32'h40000000;
    vals[0] = 32'h3F800000;
    vals[1] = 32'h3F800001;
    write_vals();
    run_sort(done_edge, busy_cycles, done_pulses);
    check_ranks("mantissa", {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
    write_cap(3'd0, 32'hBF800000);
    write_cap(3'd2, 32'h3F000000);
    run_sort(done_edge, busy_cycles, done_pulses);
    check_ranks("sign", {3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});

    // Reset mid-sort: descending data guarantees swaps have happened by now
    vals = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
             32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    write_vals();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort swap_cnt", {26'b0, swap_cnt}, 32'd0);
    check_ranks("abort", Identity);
    @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h41000000;
    @(posedge clk);
    #1 start = 1'b0; wr_en = 1'b0;
    check("reset-edge start ignored", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_pulses = 0; busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_pulses++;
      if (busy) busy_cycles++;
    end
    check("post-abort done pulses", 32'(done_pulses), 32'd0);
    check("post-abort busy", 32'(busy_cycles), 32'd0);
    // Voltages cleared and the write under reset dropped: sort of all zeros is identity
    run_sort(done_edge, busy_cycles, done_pulses);
    check("cleared swap_cnt", {26'b0, swap_cnt}, 32'd0);
    check_ranks("cleared", Identity);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
